// File: rtl/timer_periph.sv
// Memory-mapped 32-bit timer with a 16-bit prescaler, compare match, optional
// auto-reload and a level interrupt. Eight word registers in a 32-byte window.
module timer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] wData,
  output logic [31:0] rData,
  output logic        irq
);

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_COUNT    = 3'd1;
  localparam logic [2:0] REG_COMPARE  = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  // CTRL bit positions: EN, AUTO_RELOAD, IRQ_EN
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IRQ  = 2;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        match_q, match_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] pc_q, pc_d;

  logic        hit, wr, rd, tick, match_ev;
  logic [2:0]  idx;
  logic        unused_addr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++)
      if (lanes[i]) res[8*i +: 8] = new_v[8*i +: 8];
    return res;
  endfunction

  assign hit         = ce & (addr[31:5] == BASE_ADDR[31:5]);
  assign idx         = addr[4:2];
  assign wr          = hit & we;
  assign rd          = hit & ~we;
  assign unused_addr = ^addr[1:0];

  assign tick     = ctrl_q[CTRL_EN] & (pc_q == prescale_q);
  assign match_ev = tick & (count_q == compare_q);

  // NOTE: every variable gets its hold value before any branch, so no path
  // through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    ctrl_d     = ctrl_q;
    compare_d  = compare_q;
    prescale_d = prescale_q;
    match_d    = match_q;
    pc_d       = (ctrl_q[CTRL_EN] && !tick) ? pc_q + 16'd1 : 16'd0;
    count_d    = count_q;
    if (tick)
      count_d = (match_ev && ctrl_q[CTRL_AUTO]) ? 32'd0 : count_q + 32'd1;

    // CPU writes are applied on top of the tick result so written bytes win.
    if (wr) begin
      case (idx)
        REG_CTRL:     if (sel[0]) ctrl_d = wData[2:0];
        REG_COUNT:    count_d = merge_bytes(count_d, wData, sel);
        REG_COMPARE:  compare_d = merge_bytes(compare_q, wData, sel);
        REG_STATUS:   if (sel[0] && wData[0]) match_d = 1'b0;
        REG_PRESCALE: begin
          if (sel[0]) prescale_d[7:0]  = wData[7:0];
          if (sel[1]) prescale_d[15:8] = wData[15:8];
        end
        default: ;
      endcase
    end

    if (match_ev) match_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q     <= '0;
      count_q    <= '0;
      compare_q  <= 32'hFFFF_FFFF;
      match_q    <= 1'b0;
      prescale_q <= '0;
      pc_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      prescale_q <= prescale_d;
      pc_q       <= pc_d;
    end
  end

  always_comb begin
    rData = 32'h0;
    if (rd) begin
      case (idx)
        REG_CTRL:     rData = {29'h0, ctrl_q};
        REG_COUNT:    rData = count_q;
        REG_COMPARE:  rData = compare_q;
        REG_STATUS:   rData = {31'h0, match_q};
        REG_PRESCALE: rData = {16'h0, prescale_q};
        default:      rData = 32'h0;
      endcase
    end
  end

  assign irq = match_q & ctrl_q[CTRL_IRQ];

endmodule

// File: tb/tb_timer_periph.sv
// Directed bench for timer_periph: register access, prescaled counting,
// compare match, write priorities, window decode and asynchronous reset.
module tb_timer_periph;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_COUNT = BASE + 32'h04;
  localparam logic [31:0] A_CMP = BASE + 32'h08;
  localparam logic [31:0] A_STAT = BASE + 32'h0C;
  localparam logic [31:0] A_PRE = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we;
  logic [31:0] addr, wData, rData;
  logic [3:0]  sel;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_periph #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr),
    .sel(sel), .wData(wData), .rData(rData), .irq(irq)
  );

  always #5 clk = ~clk;

  // Drives just after a falling edge; the write lands on the next rising edge
  // and the task returns at the following falling edge with ce released.
  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    ce = 1'b1; we = 1'b1; addr = a; sel = s; wData = d;
    @(negedge clk);
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    ce = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
    #1 d = rData;
    ce = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    checks++;
    if (v !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, v, exp);
    end
  endtask

  task automatic expect_irq(input string name, input logic exp);
    checks++;
    if (irq !== exp) begin
      errors++;
      $display("FAIL %s: irq got %b expected %b", name, irq, exp);
    end
  endtask

  task automatic test_reset;
    expect_reg("rst_ctrl", A_CTRL, 32'h0);
    expect_reg("rst_count", A_COUNT, 32'h0);
    expect_reg("rst_compare", A_CMP, 32'hFFFF_FFFF);
    expect_reg("rst_status", A_STAT, 32'h0);
    expect_reg("rst_prescale", A_PRE, 32'h0);
    expect_irq("rst_irq", 1'b0);
    checks++;
    if (rData !== 32'h0) begin
      errors++;
      $display("FAIL rst_rdata_idle: got %08h expected 00000000", rData);
    end
  endtask

  task automatic test_regs;
    wr(A_CTRL, 4'hF, 32'hFFFF_FFF8);
    expect_reg("ctrl_mask", A_CTRL, 32'h0);
    wr(A_PRE, 4'hF, 32'hFFFF_FFFF);
    expect_reg("prescale_mask", A_PRE, 32'h0000_FFFF);
    wr(A_PRE, 4'b0001, 32'h0000_0000);
    expect_reg("prescale_byte0", A_PRE, 32'h0000_FF00);
    wr(A_PRE, 4'hF, 32'h0);
    wr(A_CMP, 4'b0000, 32'h1234_5678);
    expect_reg("sel_none", A_CMP, 32'hFFFF_FFFF);
    wr(A_CMP, 4'b0110, 32'h1234_5678);
    expect_reg("compare_mid", A_CMP + 32'h3, 32'hFF34_56FF);
  endtask

  task automatic test_prescale_match;
    wr(A_PRE, 4'hF, 32'd3);
    wr(A_CMP, 4'hF, 32'd2);
    wr(A_COUNT, 4'hF, 32'd0);
    wr(A_CTRL, 4'hF, 32'h7);
    expect_reg("pre_c0", A_COUNT, 32'd0);
    step(3);
    expect_reg("pre_c0_late", A_COUNT, 32'd0);
    step(1);
    expect_reg("pre_c1", A_COUNT, 32'd1);
    step(4);
    expect_reg("pre_c2", A_COUNT, 32'd2);
    expect_irq("pre_irq_low", 1'b0);
    step(4);
    expect_reg("pre_reload", A_COUNT, 32'd0);
    expect_reg("pre_match", A_STAT, 32'd1);
    expect_irq("pre_irq_high", 1'b1);
    wr(A_STAT, 4'hF, 32'd1);
    expect_reg("pre_cleared", A_STAT, 32'd0);
    expect_irq("pre_irq_cleared", 1'b0);
    wr(A_CTRL, 4'hF, 32'h0);
  endtask

  task automatic test_byte_write;
    wr(A_COUNT, 4'hF, 32'h0000_0100);
    wr(A_COUNT, 4'b0001, 32'hAABB_CCDD);
    expect_reg("byte_write", A_COUNT, 32'h0000_01DD);
    step(3);
    expect_reg("disabled_hold", A_COUNT, 32'h0000_01DD);
  endtask

  task automatic test_wrap;
    wr(A_PRE, 4'hF, 32'd0);
    wr(A_CMP, 4'hF, 32'd5);
    wr(A_COUNT, 4'hF, 32'hFFFF_FFFE);
    wr(A_CTRL, 4'hF, 32'h1);
    expect_reg("wrap_fffe", A_COUNT, 32'hFFFF_FFFE);
    step(1);
    expect_reg("wrap_ffff", A_COUNT, 32'hFFFF_FFFF);
    step(1);
    expect_reg("wrap_0", A_COUNT, 32'd0);
    step(1);
    expect_reg("wrap_1", A_COUNT, 32'd1);
    step(4);
    expect_reg("wrap_5", A_COUNT, 32'd5);
    expect_reg("wrap_nomatch", A_STAT, 32'd0);
    step(1);
    expect_reg("wrap_6", A_COUNT, 32'd6);
    expect_reg("wrap_match", A_STAT, 32'd1);
    expect_irq("wrap_irq_masked", 1'b0);
    wr(A_CTRL, 4'hF, 32'h0);
  endtask

  task automatic test_back_to_back;
    wr(A_STAT, 4'hF, 32'd1);
    wr(A_CMP, 4'hF, 32'd3);
    wr(A_COUNT, 4'hF, 32'd0);
    wr(A_CTRL, 4'hF, 32'h1);
    step(3);
    wr(A_STAT, 4'b0001, 32'd1);
    expect_reg("match_beats_clear", A_STAT, 32'd1);
    expect_reg("count_after_match", A_COUNT, 32'd4);
    wr(A_COUNT, 4'hF, 32'h10);
    expect_reg("write_beats_tick", A_COUNT, 32'h10);
    wr(A_COUNT, 4'b0010, 32'h0000_2000);
    expect_reg("partial_with_tick", A_COUNT, 32'h0000_2011);
    wr(A_CTRL, 4'hF, 32'h0);
    wr(A_STAT, 4'hF, 32'h0);
    expect_reg("clear_zero_noop", A_STAT, 32'd1);
  endtask

  task automatic test_decode;
    wr(A_CTRL, 4'hF, 32'h0);
    wr(A_CMP, 4'hF, 32'hCAFE_0000);
    wr(BASE + 32'h20, 4'hF, 32'hFFFF_FFFF);
    wr(BASE + 32'h28, 4'hF, 32'h1111_1111);
    wr(BASE + 32'h14, 4'hF, 32'hFFFF_FFFF);
    expect_reg("oow_read", BASE + 32'h20, 32'h0);
    expect_reg("idx5_read", BASE + 32'h14, 32'h0);
    expect_reg("idx7_read", BASE + 32'h1C, 32'h0);
    expect_reg("oow_ctrl", A_CTRL, 32'h0);
    expect_reg("oow_compare", A_CMP, 32'hCAFE_0000);
    ce = 1'b0; we = 1'b1; addr = A_CMP; sel = 4'hF; wData = 32'h0;
    step(1);
    we = 1'b0;
    expect_reg("ce_low_write", A_CMP, 32'hCAFE_0000);
  endtask

  task automatic test_async_reset;
    wr(A_PRE, 4'hF, 32'd0);
    wr(A_CMP, 4'hF, 32'd2);
    wr(A_COUNT, 4'hF, 32'd0);
    wr(A_CTRL, 4'hF, 32'h7);
    step(4);
    expect_irq("pre_reset_irq", 1'b1);
    #2 rst = 1'b0;
    #1;
    expect_irq("async_irq", 1'b0);
    rst = 1'b1;
    expect_reg("async_count", A_COUNT, 32'd0);
    step(3);
    expect_reg("after_reset_hold", A_COUNT, 32'd0);
    expect_reg("after_reset_ctrl", A_CTRL, 32'd0);
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; wData = '0;
    #23 rst = 1'b1;
    @(negedge clk);
    test_reset;
    test_regs;
    test_prescale_match;
    test_byte_write;
    test_wrap;
    test_back_to_back;
    test_decode;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_periph.md
TIMER_PERIPH -- requirements
Module: timer_periph

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000, base of the 32-byte register window (bits [4:0] zero).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ce  input  1  CPU data-port access enable.
REQ-005 SHALL have port we  input  1  write strobe (1 = write, 0 = read), valid with ce.
REQ-006 SHALL have port addr  input  32  byte address from CPU data port.
REQ-007 SHALL have port sel  input  4  byte-lane enables; sel[i] covers wData[8i+7:8i].
REQ-008 SHALL have port wData  input  32  write data.
REQ-009 SHALL have port rData  output  32  read data.
REQ-010 SHALL have port irq  output  1  interrupt request, level, active-high.

Function
REQ-011 SHALL decode hit = ce & (addr[31:5] == BASE_ADDR[31:5]); register index = addr[4:2]; addr[1:0] ignored.
REQ-012 SHALL implement registers: 0 CTRL (bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, others read 0); 1 COUNT (32b); 2 COMPARE (32b); 3 STATUS (bit0 MATCH, others 0); 4 PRESCALE (bits[15:0], upper read 0); indices 5-7 read 0, writes ignored.
REQ-013 SHALL perform writes on the clock edge when hit & we, updating only bytes whose sel bit is 1; sel = 4'b0000 writes nothing.
REQ-014 SHALL drive rData combinationally with the addressed register when hit & ~we, else 32'h0; zero wait states.
REQ-015 STATUS.MATCH SHALL be write-1-to-clear: a write with sel[0]=1 and wData[0]=1 clears it; writing 0 has no effect.
REQ-016 SHALL hold an internal 16-bit prescale counter PC; while EN=1, PC increments each cycle and a tick occurs in the cycle PC == PRESCALE, with PC <= 0 that edge.
REQ-017 While EN=0, PC SHALL be forced to 0, no ticks occur, COUNT holds.
REQ-018 PRESCALE = 0 SHALL produce a tick every cycle; PRESCALE = N produces one tick every N+1 cycles.
REQ-019 On a tick with COUNT != COMPARE, COUNT SHALL become COUNT+1 modulo 2^32 (32'hFFFF_FFFF wraps to 0, no flag).
REQ-020 On a tick with COUNT == COMPARE, MATCH SHALL be set; COUNT becomes 0 if AUTO_RELOAD=1, else COUNT+1 modulo 2^32.
REQ-021 A CPU write to COUNT SHALL take priority over a same-cycle tick update of COUNT (written bytes win; unwritten bytes take the tick-updated value).
REQ-022 A MATCH set event SHALL take priority over a same-cycle write-1-to-clear.
REQ-023 Writing CTRL.EN from 0 to 1 SHALL start PC from 0, so the first tick occurs PRESCALE+1 cycles after the write edge.
REQ-024 irq SHALL equal STATUS.MATCH & CTRL.IRQ_EN, combinational from registered state (asserts the cycle after the match edge).
REQ-025 Accesses with ce=0 or outside the window SHALL not modify any register.

Reset
REQ-026 On rst low, asynchronously: CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, PRESCALE=0, PC=0; hence irq=0; rData=0 while no read hit.
REQ-027 Reset asserted mid-count SHALL abandon the count immediately; operation resumes only after rst high and EN rewritten.

Verification
REQ-028 Reset then read all five registers -> 0, 0, 32'hFFFF_FFFF, 0, 0; irq=0.
REQ-029 PRESCALE=3, COMPARE=2, CTRL=3'b111 -> COUNT increments every 4 cycles; on tick with COUNT=2 MATCH=1, COUNT=0, irq=1 next cycle; write STATUS=1 -> irq=0.
REQ-030 Write COUNT with sel=4'b0001, wData=32'hAABBCCDD while COUNT=32'h0000_0100 and disabled -> COUNT=32'h0000_01DD.
REQ-031 AUTO_RELOAD=0, PRESCALE=0, COUNT=32'hFFFF_FFFE, COMPARE=5 -> COUNT reads FFFF_FFFF, 0, 1, ...; MATCH sets when COUNT goes 5->6.
REQ-032 Clear-write to STATUS in the same cycle as a match tick -> MATCH reads 1 afterwards; write to COUNT=32'h10 on a tick cycle -> COUNT reads 32'h10.
REQ-033 Read/write at BASE_ADDR+32'h20 and at index 5 -> rData=0, no register changes.
